os_input_buf: RTL

OS_INPUT_BUF -- requirements
Module: os_input_buf

---
 rtl/os_input_buf.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/os_input_buf.sv
// Oversampled polyphase input buffer.
// Collects D new ADC samples per frame into an M-deep circular history and then
// streams the M most recent samples, newest first, to an M-branch polyphase FIR.
// Branches older than the samples written since reset are forced to zero, so
// the start-up frames see a zero history without the buffer being cleared.
module os_input_buf #(
  parameter int M     = 8,
  parameter int D     = 6,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_start
);

  localparam int AW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(M + 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [AW-1:0]    wptr_r, wptr_nxt_s;
  logic [AW-1:0]    rptr_r, rptr_nxt_s;
  logic [CW-1:0]    fcnt_r, fcnt_nxt_s;
  logic [CW-1:0]    hist_r, hist_nxt_s;
  logic [CW-1:0]    lcnt_r, lcnt_nxt_s;
  logic [WIDTH-1:0] dout_r, dout_nxt_s;
  logic             dout_valid_r, dout_valid_nxt_s;
  logic             frame_start_r, frame_start_nxt_s;
  logic             din_ready_r, din_ready_nxt_s;
  logic             wr_en_s;
  logic [WIDTH-1:0] mem_r [M];

  // Next-state, pointer and output-register logic for the FILL/EMIT FSM.
  always_comb begin
    state_nxt_s       = state_r;
    wptr_nxt_s        = wptr_r;
    rptr_nxt_s        = rptr_r;
    fcnt_nxt_s        = fcnt_r;
    hist_nxt_s        = hist_r;
    lcnt_nxt_s        = lcnt_r;
    dout_nxt_s        = dout_r;
    dout_valid_nxt_s  = dout_valid_r;
    frame_start_nxt_s = frame_start_r;
    wr_en_s           = 1'b0;
    case (state_r)
      ST_FILL: begin
        if (din_valid && din_ready_r) begin
          wr_en_s    = 1'b1;
          wptr_nxt_s = (wptr_r == AW'(M - 1)) ? {AW{1'b0}} : wptr_r + AW'(1);
          hist_nxt_s = (hist_r == CW'(M)) ? hist_r : hist_r + CW'(1);
          if (fcnt_r == CW'(D - 1)) begin
            // Last new sample of the frame: newest sample sits at the
            // current write pointer, so the read-out starts there.
            state_nxt_s = ST_EMIT;
            fcnt_nxt_s  = {CW{1'b0}};
            rptr_nxt_s  = wptr_r;
            lcnt_nxt_s  = {CW{1'b0}};
          end else begin
            fcnt_nxt_s = fcnt_r + CW'(1);
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_EMIT: begin
        if (!dout_valid_r || dout_ready) begin
          if (lcnt_r != CW'(M)) begin
            // Load the next branch word; offsets beyond the written history read as zero.
            dout_nxt_s        = (lcnt_r < hist_r) ? mem_r[rptr_r] : {WIDTH{1'b0}};
            dout_valid_nxt_s  = 1'b1;
            frame_start_nxt_s = (lcnt_r == {CW{1'b0}});
            rptr_nxt_s        = (rptr_r == {AW{1'b0}}) ? AW'(M - 1) : rptr_r - AW'(1);
            lcnt_nxt_s        = lcnt_r + CW'(1);
          end else begin
            // The M-th word has just been taken: close the frame.
            dout_valid_nxt_s  = 1'b0;
            frame_start_nxt_s = 1'b0;
            state_nxt_s       = ST_FILL;
          end
        end else begin
          // Downstream stalled: hold the presented word.
          dout_valid_nxt_s = dout_valid_r;
        end
      end
      default: begin
        state_nxt_s       = ST_FILL;
        dout_valid_nxt_s  = 1'b0;
        frame_start_nxt_s = 1'b0;
      end
    endcase
    din_ready_nxt_s = (state_nxt_s == ST_FILL);
  end

  // State, pointers, counters and registered outputs with async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_FILL;
      wptr_r        <= {AW{1'b0}};
      rptr_r        <= {AW{1'b0}};
      fcnt_r        <= {CW{1'b0}};
      hist_r        <= {CW{1'b0}};
      lcnt_r        <= {CW{1'b0}};
      dout_r        <= {WIDTH{1'b0}};
      dout_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
      din_ready_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      wptr_r        <= wptr_nxt_s;
      rptr_r        <= rptr_nxt_s;
      fcnt_r        <= fcnt_nxt_s;
      hist_r        <= hist_nxt_s;
      lcnt_r        <= lcnt_nxt_s;
      dout_r        <= dout_nxt_s;
      dout_valid_r  <= dout_valid_nxt_s;
      frame_start_r <= frame_start_nxt_s;
      din_ready_r   <= din_ready_nxt_s;
    end
  end

  // History storage; deliberately not reset, stale entries are masked by hist_r.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wptr_r] <= din;
    end
  end

  assign din_ready   = din_ready_r;
  assign dout        = dout_r;
  assign dout_valid  = dout_valid_r;
  assign frame_start = frame_start_r;

endmodule
